// File: rtl/mem_pkg.sv
// Shared types for the memory-port arbiter.
//   state_e    : arbiter FSM states
//   owner_e    : which requester owns the in-flight transaction
//   size_e     : access size encodings used for the alignment check
//   misaligned : true when an access of the given size is not naturally aligned
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Only the two low address bits matter for natural alignment.
  // Unknown size codes are treated like bytes and never fault.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory-port signals.
//   master : arbiter view (accepts requests, drives the memory port)
//   slave  : environment view (requesters plus memory)
// Fetch   : if_valid/if_ready/if_addr request, if_rvalid/if_rdata response
// Data    : d_valid/d_ready/d_addr/d_bytes/d_size/d_wdata request,
//           d_rvalid/d_rdata/d_err response
// Memory  : mem_req/mem_ready/mem_addr/mem_bytes_to_write/mem_wdata request,
//           mem_rvalid/mem_rdata completion
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_valid;
  logic              d_ready;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_bytes;
  logic [1:0]        d_size;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_bytes_to_write;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_valid, if_addr,
    output if_ready, if_rvalid, if_rdata,
    input  d_valid, d_addr, d_bytes, d_size, d_wdata,
    output d_ready, d_rvalid, d_rdata, d_err,
    output mem_req, mem_addr, mem_bytes_to_write, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_valid, if_addr,
    input  if_ready, if_rvalid, if_rdata,
    output d_valid, d_addr, d_bytes, d_size, d_wdata,
    input  d_ready, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_addr, mem_bytes_to_write, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arb_prio.sv
// Priority decision between fetch and data requests plus the data-streak
// counter that bounds fetch starvation.
//   clk, rst_n        : clock, async active-low reset
//   idle              : arbiter is free to grant this cycle
//   if_valid, d_valid : pending requests
//   grant_if, grant_d : one-hot grant (combinational)
module mem_arb_prio #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);

  localparam int SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_DATA_STREAK);
  localparam logic [SW-1:0] ONE_S = SW'(1);

  logic [SW-1:0] streak;

  // Data wins unless it has already taken MAX_DATA_STREAK grants in a row
  // while a fetch was waiting.
  always_comb begin
    grant_d  = idle && d_valid && ((streak < MAX_S) || !if_valid);
    grant_if = idle && if_valid && !grant_d;
  end

  // The streak only counts data grants that actually delayed a fetch; it is
  // frozen while a transaction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (idle) begin
      if (!if_valid || grant_if) begin
        streak <= '0;
      end else if (grant_d && (streak < MAX_S)) begin
        streak <= streak + ONE_S;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction in flight; data has priority with bounded fetch starvation;
// misaligned data accesses are answered with an error without a memory access.
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_arbiter_if.master (requester and memory signals)
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  state_e            state;
  owner_e            owner;
  logic              mem_req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        bytes_q;

  logic              idle;
  logic              grant_if;
  logic              grant_d;
  logic [1:0]        d_acc_size;
  logic              d_mis;
  logic              resp;
  logic              d_resp;

  // Gating with rst_n keeps readys low while reset is held.
  assign idle = (state == IDLE) && rst_n;

  mem_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle     (idle),
    .if_valid (bus.if_valid),
    .d_valid  (bus.d_valid),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  // Stores carry their size in d_bytes, loads in d_size.
  always_comb begin
    d_acc_size = SZ_BYTE;
    if (bus.d_bytes == 3'd0) begin
      d_acc_size = bus.d_size;
    end else if (bus.d_bytes == 3'd4) begin
      d_acc_size = SZ_WORD;
    end else if (bus.d_bytes == 3'd2) begin
      d_acc_size = SZ_HALF;
    end
  end

  assign d_mis = misaligned(bus.d_addr[1:0], d_acc_size);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      mem_req_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bytes_q   <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            owner <= OWN_D;
            if (d_mis) begin
              state <= ERR;
            end else begin
              state     <= REQ;
              mem_req_q <= 1'b1;
              addr_q    <= bus.d_addr;
              wdata_q   <= bus.d_wdata;
              bytes_q   <= bus.d_bytes;
            end
          end else if (grant_if) begin
            owner     <= OWN_IF;
            state     <= REQ;
            mem_req_q <= 1'b1;
            addr_q    <= bus.if_addr;
            wdata_q   <= '0;
            bytes_q   <= 3'd0;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // The completion cycle is never also a grant cycle.
          if (bus.mem_rvalid) begin
            state <= IDLE;
          end
        end
        ERR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.if_ready           = grant_if;
  assign bus.d_ready            = grant_d;
  assign bus.mem_req            = mem_req_q;
  assign bus.mem_addr           = addr_q;
  assign bus.mem_bytes_to_write = bytes_q;
  assign bus.mem_wdata          = wdata_q;

  // Responses are passed straight through in the completion cycle; rdata is
  // forced to zero outside a response so it never leaks stale memory data.
  assign resp   = (state == WAIT) && bus.mem_rvalid;
  assign d_resp = resp && (owner == OWN_D);

  assign bus.if_rvalid = resp && (owner == OWN_IF);
  assign bus.if_rdata  = (resp && (owner == OWN_IF)) ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = d_resp || (state == ERR);
  assign bus.d_rdata   = d_resp ? bus.mem_rdata : '0;
  assign bus.d_err     = (state == ERR);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  bytes;
    logic [31:0] wdata;
  } mtx_t;

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  logic [31:0] if_q[$];
  logic [32:0] d_q[$];
  int          if_times[$];
  int          d_pulses = 0;
  bit          d_ready_seen = 1'b0;
  mtx_t        mlog[$];
  int          lat = 1;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pa = 32'd0;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Memory model: accepts when mem_req && mem_ready, answers lat cycles later.
  always @(posedge clk) begin : mem_model
    logic acc;
    mtx_t t;
    acc = bus.mem_req && bus.mem_ready;
    t.addr = bus.mem_addr;
    t.bytes = bus.mem_bytes_to_write;
    t.wdata = bus.mem_wdata;
    #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'd0;
    if (acc) begin
      pend = 1'b1;
      cnt = lat;
      pa = t.addr;
      mlog.push_back(t);
    end
    if (pend) begin
      if (cnt <= 1) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = rd_of(pa);
        pend = 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [31:0] ei;
    logic [32:0] ed;
    if (bus.d_ready) d_ready_seen = 1'b1;
    if (bus.if_rvalid) begin
      if_times.push_back(cyc);
      if (if_q.size() == 0) begin
        checks++;
        $display("FAIL if_unexpected: got if_rvalid rdata 0x%0h, expected no response", bus.if_rdata);
      end else begin
        ei = if_q.pop_front();
        chk("if_rdata", 64'(bus.if_rdata), 64'(ei));
      end
    end
    if (bus.d_rvalid) begin
      d_pulses++;
      if (d_q.size() == 0) begin
        checks++;
        $display("FAIL d_unexpected: got d_rvalid rdata 0x%0h err %0b, expected no response",
                 bus.d_rdata, bus.d_err);
      end else begin
        ed = d_q.pop_front();
        chk("d_rdata", 64'(bus.d_rdata), 64'(ed[31:0]));
        chk("d_err", 64'(bus.d_err), 64'(ed[32]));
      end
    end
  end

  task automatic wait_if(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.if_ready) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL if_grant_timeout: got no if_ready, expected one within 50 cycles");
    end
  endtask

  task automatic wait_d(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.d_ready) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL d_grant_timeout: got no d_ready, expected one within 50 cycles");
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a data request, returns at the negedge of the grant cycle.
  task automatic d_req(input logic [31:0] a, input logic [2:0] b, input logic [1:0] s,
                       input logic [31:0] w, output bit ok);
    bus.d_addr = a;
    bus.d_bytes = b;
    bus.d_size = s;
    bus.d_wdata = w;
    bus.d_valid = 1'b1;
    wait_d(ok);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no end of test, expected finish before 300000");
    $fatal(1);
  end

  initial begin : stim
    bit    ok;
    int    n;
    int    dp0;
    string grants;
    mtx_t  m;

    bus.if_valid = 1'b0; bus.if_addr = 32'd0;
    bus.d_valid = 1'b0; bus.d_addr = 32'd0; bus.d_bytes = 3'd0; bus.d_size = 2'd0;
    bus.d_wdata = 32'd0; bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_if_ready", 64'(bus.if_ready), 64'd0);
    chk("rst_d_ready", 64'(bus.d_ready), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_mem_bytes", 64'(bus.mem_bytes_to_write), 64'd0);
    chk("rst_rvalids", 64'({bus.if_rvalid, bus.d_rvalid, bus.d_err}), 64'd0);
    chk("rst_rdata", 64'({bus.if_rdata, bus.d_rdata}), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Fetch only, zero-wait memory
    if_times.delete(); mlog.delete(); d_ready_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.if_addr = 32'(i * 4);
      bus.if_valid = 1'b1;
      wait_if(ok);
      if (ok) if_q.push_back(rd_of(32'(i * 4)));
      step();
    end
    bus.if_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("fetch_count", 64'(if_times.size()), 64'd3);
    if (if_times.size() == 3) begin
      chk("fetch_gap1", 64'(if_times[1] - if_times[0]), 64'd3);
      chk("fetch_gap2", 64'(if_times[2] - if_times[1]), 64'd3);
    end
    chk("fetch_no_d_ready", 64'(d_ready_seen), 64'd0);
    chk("fetch_mem_count", 64'(mlog.size()), 64'd3);
    for (int i = 0; i < 3 && mlog.size() > 0; i++) begin
      m = mlog.pop_front();
      chk("fetch_mem_addr", 64'(m.addr), 64'(i * 4));
      chk("fetch_mem_bytes", 64'(m.bytes), 64'd0);
    end
    step();

    // Both valids held: DDDDIDDDDI
    grants = "";
    bus.d_addr = 32'h200; bus.d_bytes = 3'd0; bus.d_size = 2'd2; bus.d_wdata = 32'd0;
    bus.if_addr = 32'h40;
    bus.d_valid = 1'b1; bus.if_valid = 1'b1;
    n = 0;
    while (grants.len() < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.d_ready) begin grants = {grants, "D"}; d_q.push_back({1'b0, rd_of(32'h200)}); end
      if (bus.if_ready) begin grants = {grants, "I"}; if_q.push_back(rd_of(32'h40)); end
    end
    step();
    bus.d_valid = 1'b0; bus.if_valid = 1'b0;
    checks++;
    if (grants == "DDDDIDDDDI") passes++;
    else $display("FAIL grant_order: got %s, expected DDDDIDDDDI", grants);
    repeat (5) @(negedge clk);
    step();

    // Misaligned store word at 0x102
    mlog.delete();
    d_req(32'h102, 3'd4, 2'd0, 32'h5555_AAAA, ok);
    if (ok) d_q.push_back({1'b1, 32'd0});
    step();
    bus.d_valid = 1'b0;
    @(negedge clk);
    chk("mis_st_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("mis_st_err", 64'(bus.d_err), 64'd1);
    chk("mis_st_mem_req", 64'(bus.mem_req), 64'd0);
    step();

    // Misaligned load half at 0x103
    d_req(32'h103, 3'd0, 2'd1, 32'd0, ok);
    if (ok) d_q.push_back({1'b1, 32'd0});
    step();
    bus.d_valid = 1'b0;
    @(negedge clk);
    chk("mis_ld_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("mis_ld_err", 64'(bus.d_err), 64'd1);
    chk("mis_ld_mem_req", 64'(bus.mem_req), 64'd0);
    repeat (2) @(negedge clk);
    chk("mis_no_mem", 64'(mlog.size()), 64'd0);
    step();

    // Byte load at 0x103 is fine
    d_req(32'h103, 3'd0, 2'd0, 32'd0, ok);
    if (ok) d_q.push_back({1'b0, rd_of(32'h103)});
    step();
    bus.d_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("byte_ld_mem_count", 64'(mlog.size()), 64'd1);
    if (mlog.size() > 0) begin
      m = mlog.pop_front();
      chk("byte_ld_mem_addr", 64'(m.addr), 64'h103);
      chk("byte_ld_mem_bytes", 64'(m.bytes), 64'd0);
    end
    step();

    // Memory stall: 5 cycles of mem_ready low
    mlog.delete();
    bus.mem_ready = 1'b0;
    d_req(32'h20, 3'd4, 2'd0, 32'h1234_5678, ok);
    if (ok) d_q.push_back({1'b0, rd_of(32'h20)});
    step();
    bus.d_valid = 1'b0;
    bus.if_addr = 32'h60;
    bus.if_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_mem_req", 64'(bus.mem_req), 64'd1);
      chk("stall_mem_addr", 64'(bus.mem_addr), 64'h20);
      chk("stall_mem_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
      chk("stall_mem_bytes", 64'(bus.mem_bytes_to_write), 64'd4);
      chk("stall_readys", 64'({bus.if_ready, bus.d_ready}), 64'd0);
    end
    step();
    bus.mem_ready = 1'b1;
    wait_if(ok);
    if (ok) if_q.push_back(rd_of(32'h60));
    step();
    bus.if_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_mem_count", 64'(mlog.size()), 64'd2);
    if (mlog.size() == 2) begin
      chk("stall_st_bytes", 64'(mlog[0].bytes), 64'd4);
      chk("stall_if_addr", 64'(mlog[1].addr), 64'h60);
    end
    step();

    // Reset during WAIT, late mem_rvalid afterwards
    lat = 4;
    bus.if_addr = 32'h80;
    bus.if_valid = 1'b1;
    wait_if(ok);
    step();
    bus.if_valid = 1'b0;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", 64'(bus.mem_req), 64'd0);
    step();
    rst_n = 1'b1;
    ok = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (bus.mem_rvalid) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL late_rvalid_timeout: got no late mem_rvalid, expected one within 20 cycles");
    end else begin
      chk("late_no_if_rvalid", 64'(bus.if_rvalid), 64'd0);
      chk("late_no_d_rvalid", 64'(bus.d_rvalid), 64'd0);
    end
    step();
    lat = 1;
    bus.if_addr = 32'h84;
    bus.if_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.if_ready), 64'd1);
    if (bus.if_ready) if_q.push_back(rd_of(32'h84));
    step();
    bus.if_valid = 1'b0;
    repeat (4) @(negedge clk);
    step();

    // Half-word store at 0x10
    mlog.delete();
    dp0 = d_pulses;
    d_req(32'h10, 3'd2, 2'd0, 32'h0000_ABCD, ok);
    if (ok) d_q.push_back({1'b0, rd_of(32'h10)});
    step();
    bus.d_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("st2_mem_count", 64'(mlog.size()), 64'd1);
    if (mlog.size() > 0) begin
      m = mlog.pop_front();
      chk("st2_mem_addr", 64'(m.addr), 64'h10);
      chk("st2_mem_bytes", 64'(m.bytes), 64'd2);
      chk("st2_mem_wdata", 64'(m.wdata), 64'h0000_ABCD);
    end
    chk("st2_pulse_count", 64'(d_pulses - dp0), 64'd1);

    chk("if_queue_drained", 64'(if_q.size()), 64'd0);
    chk("d_queue_drained", 64'(d_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the CPU's single memory port between the instruction-fetch requester and the load/store requester once the core moves from single-cycle to multi-cycle operation. Each requester uses a valid/ready request handshake and receives a one-cycle response pulse. The arbiter allows one outstanding memory transaction, gives data accesses priority with a bounded fetch-starvation limit, and rejects misaligned data accesses without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MAX_DATA_STREAK`, 4: maximum consecutive data grants while a fetch is pending; minimum 1.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, asynchronous assert, active-low (decided: one clock; reset is asynchronous and active-low).
- `if_valid` in 1: fetch request.
- `if_ready` out 1: fetch request accepted this cycle.
- `if_addr` in ADDR_W: fetch address.
- `if_rvalid` out 1: fetch response pulse.
- `if_rdata` out DATA_W: instruction word; valid only with `if_rvalid`.
- `d_valid` in 1: data request.
- `d_ready` out 1: data request accepted this cycle.
- `d_addr` in ADDR_W: data address.
- `d_bytes` in 3: 0 = load, 1/2/4 = store bytes.
- `d_size` in 2: load size, 0 = byte, 1 = half, 2 = word.
- `d_wdata` in DATA_W: store data.
- `d_rvalid` out 1: data response pulse, for loads and store-acks.
- `d_rdata` out DATA_W: raw load word.
- `d_err` out 1: misaligned access; valid with `d_rvalid`.
- `mem_req` out 1: memory request.
- `mem_ready` in 1: memory accepts `mem_req`.
- `mem_addr` out ADDR_W: memory address.
- `mem_bytes_to_write` out 3: 0 = read.
- `mem_wdata` out DATA_W: store data.
- `mem_rvalid` in 1: memory completion.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- FSM states:
  - `IDLE`: arbitrate.
  - `REQ`: hold `mem_req` until `mem_ready`.
  - `WAIT`: wait for `mem_rvalid`.
  - `ERR`: one-cycle error response.
- Arbitration in `IDLE`:
  - If `d_valid` is high and the streak is below `MAX_DATA_STREAK`, or `if_valid` is low, grant data.
  - Otherwise, if `if_valid` is high, grant fetch.
- Grant effects: assert the winner's ready for one cycle, latch owner and request fields, and go to `REQ`.
- Streak counter:
  - Increments on each data grant while `if_valid` is high.
  - Clears on a fetch grant, or whenever `if_valid` is low in `IDLE`.
  - Saturates at `MAX_DATA_STREAK`.
- Misalignment check on data grant:
  - Half access requires `addr[0]=0`; word access requires `addr[1:0]=0`. Access size comes from `d_bytes` for stores and `d_size` for loads.
  - A misaligned access still asserts `d_ready`, then goes to `ERR`. No `mem_req` is issued.
  - The next cycle gives `d_rvalid=1`, `d_err=1`, `d_rdata=0`, then returns to `IDLE`.
- `REQ`: `mem_*` outputs are driven from latched fields and held stable until `mem_ready`, then go to `WAIT`.
- `WAIT`: on `mem_rvalid`, pulse the owner's `rvalid` with `rdata=mem_rdata` and `d_err=0`, then go to `IDLE`. Stores also receive `d_rvalid`.
- The `mem_rvalid` cycle is not also an arbitration cycle; the next grant is at the earliest the following cycle.
- `mem_rvalid` outside `WAIT` is ignored.
- Requester rule: fields must be held stable while valid is high and ready is low.

## Timing
- Reset values:
  - All outputs 0, FSM in `IDLE`, streak 0.
  - `mem_addr`, `mem_wdata`, `if_rdata` and `d_rdata` are 0.
- Asserting `rst_n` mid-transaction aborts it with no response pulse. A late `mem_rvalid` after reset is ignored.
- Grant latency:
  - Ready combinationally in the same cycle as valid when in `IDLE`.
  - `mem_req` rises the next cycle.
- Zero-wait memory (`mem_ready=1`, `mem_rvalid` one cycle after acceptance): grant in cycle 0, `mem_req` in cycle 1, response pulse in cycle 2, next grant in cycle 3.
- Misaligned access: grant in cycle 0, error response in cycle 1.
- Both valids arrive in the same cycle with streak 0: data wins.

## Structure
- Package `mem_pkg`:
  - FSM state enum.
  - Owner enum (`OWN_IF`, `OWN_D`).
  - Size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`).
  - Function `misaligned(addr, size)`.
- Sub-module `mem_arb_prio`: combinational priority decision plus streak counter register.
- Shared with `cpu` refactor: `d_bytes` encoding matches the memory's `bytes_to_write`.

## Test plan
- Fetch only, zero-wait memory, `if_addr=0x0,0x4,0x8`: one `if_rvalid` every 3 cycles with `mem_rdata` echoed, and `d_ready` never asserted.
- Both valids held with `MAX_DATA_STREAK=4`: grant order D,D,D,D,IF,D,D,D,D,IF; the streak resets after each fetch grant.
- Store with `d_bytes=4`, `d_addr=0x102`: `d_rvalid=1`, `d_err=1` one cycle after grant, and `mem_req` stays 0. Load with `d_size=1`, `addr=0x103`: same error response. Load with `d_size=0`, `addr=0x103`: accepted and issued to memory.
- `mem_ready` low for 5 cycles: `mem_addr`, `mem_wdata` and `mem_bytes_to_write` stay stable, and both requester readys stay 0.
- `rst_n` low during `WAIT`, then `mem_rvalid` arrives after release: no response pulse, FSM in `IDLE`, and the next fetch grant is immediate.
- Store `d_bytes=2`, `addr=0x10`, `wdata=0xABCD`: memory sees `bytes_to_write=2`, `addr=0x10`, `wdata=0xABCD`, and `d_rvalid` pulses once.
